return_stack: RTL and testbench

Hardware return-address stack for the Salamander-4 control path.
- On a CALL it captures the return address derived from the current program-counter value and loads the call target into the program counter.
- On a RET it pops the most recent return address and loads it back into the program counter.
- It is the reader/writer counterpart of the program counter's jump port: it consumes `cnt_val` and drives `cnt_overwrite` / `cnt_new_val`.
- It sits between the instruction decoder and the program counter.

---
 rtl/return_stack.sv | 139 +++++++++++++
 tb/tb_return_stack.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// Return-address stack between decoder and program counter: pushes pc+1 on CALL, pops on RET,
// and drives the PC jump port. Optional `RSTACK_WRAP_EN: a CALL while full overwrites the oldest entry.
module return_stack #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           call,
  input  logic                           ret,
  input  logic [ADDR_W-1:0]              pc_val,
  input  logic [ADDR_W-1:0]              call_target,
  input  logic                           err_clr,
  output logic                           pc_load,
  output logic [ADDR_W-1:0]              pc_load_val,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           empty,
  output logic                           full,
  output logic                           ovf_err,
  output logic                           unf_err,
  output logic                           addr_err
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] MAX     = '1;
  localparam logic [PTR_W-1:0]  PTR_TOP = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W-1:0] pc_load_val_q, pc_load_val_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              addr_q, addr_d;

  logic [ADDR_W-1:0] ra_c;
  logic [PTR_W-1:0]  ptr_inc_c;
  logic [PTR_W-1:0]  ptr_dec_c;
  logic              addr_bad_c;
  logic              is_full_c;
  logic              is_empty_c;

  // wr_ptr_q names the next free slot; when full it also names the oldest entry.
  assign ra_c       = pc_val + ADDR_W'(1);
  assign ptr_inc_c  = (wr_ptr_q == PTR_TOP) ? '0 : wr_ptr_q + PTR_W'(1);
  assign ptr_dec_c  = (wr_ptr_q == '0) ? PTR_TOP : wr_ptr_q - PTR_W'(1);
  assign addr_bad_c = (call_target == MAX) || (ra_c == MAX);
  assign is_full_c  = (level_q == LVL_MAX);
  assign is_empty_c = (level_q == '0);

  // Next-state for storage, pointer, level, load port and sticky errors.
  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    level_d       = level_q;
    pc_load_d     = 1'b0;
    pc_load_val_d = pc_load_val_q;
    ovf_d         = err_clr ? 1'b0 : ovf_q;
    unf_d         = err_clr ? 1'b0 : unf_q;
    addr_d        = err_clr ? 1'b0 : addr_q;

    if (call && ret) begin
      ovf_d = 1'b1;
      unf_d = 1'b1;
    end else if (call) begin
      if (addr_bad_c) begin
        addr_d = 1'b1;
      end else if (!is_full_c) begin
        mem_d[wr_ptr_q] = ra_c;
        wr_ptr_d        = ptr_inc_c;
        level_d         = level_q + LVL_W'(1);
        pc_load_d       = 1'b1;
        pc_load_val_d   = call_target;
      end else begin
        ovf_d = 1'b1;
`ifdef RSTACK_WRAP_EN
        mem_d[wr_ptr_q] = ra_c;
        wr_ptr_d        = ptr_inc_c;
        pc_load_d       = 1'b1;
        pc_load_val_d   = call_target;
`endif
      end
    end else if (ret) begin
      if (!is_empty_c) begin
        wr_ptr_d      = ptr_dec_c;
        level_d       = level_q - LVL_W'(1);
        pc_load_d     = 1'b1;
        pc_load_val_d = mem_q[ptr_dec_c];
      end else begin
        unf_d = 1'b1;
      end
    end

    empty_d = (level_d == '0);
    full_d  = (level_d == LVL_MAX);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      level_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_load_val_q <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      addr_q        <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      level_q       <= level_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      pc_load_q     <= pc_load_d;
      pc_load_val_q <= pc_load_val_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
      addr_q        <= addr_d;
    end
  end

  assign pc_load     = pc_load_q;
  assign pc_load_val = pc_load_val_q;
  assign level       = level_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;
  assign addr_err    = addr_q;

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: directed test-plan steps then random traffic, checked against a queue model.
module tb_return_stack;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
  localparam int MAXV = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              call = 1'b0;
  logic              ret = 1'b0;
  logic [ADDR_W-1:0] pc_val = '0;
  logic [ADDR_W-1:0] call_target = '0;
  logic              err_clr = 1'b0;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic [LVL_W-1:0]  level;
  logic              empty, full, ovf_err, unf_err, addr_err;

  return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .call(call), .ret(ret), .pc_val(pc_val),
    .call_target(call_target), .err_clr(err_clr), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .level(level), .empty(empty), .full(full),
    .ovf_err(ovf_err), .unf_err(unf_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: a queue of return addresses, newest at the back.
  int stk[$];
  int m_load = 0, m_val = 0, m_ovf = 0, m_unf = 0, m_addr = 0;

`ifdef RSTACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc_load"},  int'(pc_load), m_load);
    chk({tag, ".pc_val"},   int'(pc_load_val), m_val);
    chk({tag, ".level"},    int'(level), stk.size());
    chk({tag, ".empty"},    int'(empty), (stk.size() == 0) ? 1 : 0);
    chk({tag, ".full"},     int'(full), (stk.size() == DEPTH) ? 1 : 0);
    chk({tag, ".ovf"},      int'(ovf_err), m_ovf);
    chk({tag, ".unf"},      int'(unf_err), m_unf);
    chk({tag, ".addr"},     int'(addr_err), m_addr);
  endtask

  task automatic model_reset();
    stk.delete();
    m_load = 0; m_val = 0; m_ovf = 0; m_unf = 0; m_addr = 0;
  endtask

  task automatic model_step(input bit c, input bit r, input int pcv, input int tgt, input bit clr);
    int ra;
    ra = (pcv + 1) % (MAXV + 1);
    m_load = 0;
    if (clr) begin m_ovf = 0; m_unf = 0; m_addr = 0; end
    if (c && r) begin
      m_ovf = 1; m_unf = 1;
    end else if (c) begin
      if (tgt == MAXV || ra == MAXV) m_addr = 1;
      else if (stk.size() < DEPTH) begin
        stk.push_back(ra); m_load = 1; m_val = tgt;
      end else begin
        m_ovf = 1;
        if (WRAP) begin
          void'(stk.pop_front()); stk.push_back(ra); m_load = 1; m_val = tgt;
        end
      end
    end else if (r) begin
      if (stk.size() > 0) begin m_val = stk.pop_back(); m_load = 1; end
      else m_unf = 1;
    end
  endtask

  // One clock of stimulus; outputs sampled 1 time unit after the edge.
  task automatic step(input string tag, input bit c, input bit r, input int pcv,
                      input int tgt, input bit clr);
    @(negedge clk);
    call = c; ret = r; pc_val = ADDR_W'(pcv); call_target = ADDR_W'(tgt); err_clr = clr;
    @(posedge clk);
    #1;
    call = 1'b0; ret = 1'b0; err_clr = 1'b0;
    model_step(c, r, pcv, tgt, clr);
    chk_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int rets_exp [4];
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Basic CALL/RET
    step("call3", 1, 0, 3, 20, 0);
    chk("call3.val20", int'(pc_load_val), 20);
    idle("idle0");
    step("ret1", 0, 1, 0, 0, 0);
    chk("ret1.val4", int'(pc_load_val), 4);
    idle("idle1");

    // Nesting to full
    step("nest1", 1, 0, 1, 10, 0);
    step("nest2", 1, 0, 5, 11, 0);
    step("nest3", 1, 0, 9, 12, 0);
    step("nest4", 1, 0, 13, 16, 0);
    chk("nest4.full", int'(full), 1);

    // Overflow
    step("ovf", 1, 0, 20, 7, 0);
    chk("ovf.flag", int'(ovf_err), 1);
    chk("ovf.load", int'(pc_load), WRAP ? 1 : 0);
    if (WRAP) begin
      rets_exp[0] = 21; rets_exp[1] = 14; rets_exp[2] = 10; rets_exp[3] = 6;
    end else begin
      rets_exp[0] = 14; rets_exp[1] = 10; rets_exp[2] = 6; rets_exp[3] = 2;
    end
    for (int i = 0; i < 4; i++) begin
      step("unwind", 0, 1, 0, 0, 0);
      chk("unwind.val", int'(pc_load_val), rets_exp[i]);
    end
    step("clr0", 0, 0, 0, 0, 1);

    // Underflow and clear
    step("unf", 0, 1, 0, 0, 0);
    chk("unf.flag", int'(unf_err), 1);
    step("unfclr", 0, 0, 0, 0, 1);
    chk("unfclr.flag", int'(unf_err), 0);

    // Address boundaries
    step("pc30", 1, 0, 30, 5, 0);
    step("tgt31", 1, 0, 2, 31, 0);
    step("addrclr", 0, 0, 0, 0, 1);
    step("pc31", 1, 0, 31, 9, 0);
    step("pc31ret", 0, 1, 0, 0, 0);
    chk("pc31ret.val0", int'(pc_load_val), 0);

    // Conflict; then error raised in the same cycle as clear
    step("cf1", 1, 0, 4, 8, 0);
    step("cf2", 1, 0, 6, 9, 0);
    step("both", 1, 1, 7, 3, 0);
    chk("both.level", int'(level), 2);
    step("clr_vs_new", 1, 0, 30, 3, 1);
    idle("idle2");

    // Asynchronous reset mid-sequence
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk_all("midrst");
    @(negedge clk);
    rstn = 1'b1;

    // Random traffic with biased boundary values
    for (int n = 0; n < 400; n++) begin
      int sel, pcv, tgt;
      bit c, r, clr;
      sel = int'($urandom_range(0, 99));
      c = (sel < 40) || (sel >= 95);
      r = (sel >= 40 && sel < 75) || (sel >= 95);
      clr = ($urandom_range(0, 15) == 0);
      pcv = ($urandom_range(0, 9) == 0) ? MAXV - int'($urandom_range(0, 1)) : int'($urandom_range(0, MAXV));
      tgt = ($urandom_range(0, 11) == 0) ? MAXV : int'($urandom_range(0, MAXV));
      step("rand", c, r, pcv, tgt, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
